// File: rtl/rf_writeback_scheduler.sv
// Register-file writeback scheduler: per-source FIFOs feeding up to WRITE_PORTS conflict-free writes per cycle.
// Optional `RF_WB_ZERO_DROP_EN: requests to register 0 are discarded at the FIFO head.
module rf_wb_fifo #(
  parameter int AW    = 5,
  parameter int WW    = 32,
  parameter int DEPTH = 2,
  localparam int DW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] addr,
  input  logic [WW-1:0] data,
  output logic [AW-1:0] head_addr,
  output logic [WW-1:0] head_data,
  output logic [DW:0]   count
);
  logic [DEPTH-1:0][AW-1:0] mem_addr;
  logic [DEPTH-1:0][WW-1:0] mem_data;
  logic [DW-1:0] rd, wr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr] <= addr;
      mem_data[wr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop)  rd <= rd + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_addr = mem_addr[rd];
  assign head_data = mem_data[rd];
endmodule

module rf_writeback_scheduler #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int SOURCES       = 4,
  parameter int WRITE_PORTS   = 2,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                                        clk_i,
  input  logic                                        srst_i,
  input  logic [SOURCES-1:0]                          src_valid_i,
  output logic [SOURCES-1:0]                          src_ready_o,
  input  logic [SOURCES-1:0][ADDRESS_WIDTH-1:0]       src_addr_i,
  input  logic [SOURCES-1:0][WORD_WIDTH-1:0]          src_data_i,
  output logic [WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0]   select_r_o,
  output logic [WRITE_PORTS-1:0][WORD_WIDTH-1:0]      data_o,
  output logic [WRITE_PORTS-1:0]                      enable_writing_o,
  output logic                                        busy_o
);
  localparam int DW = $clog2(FIFO_DEPTH);
  localparam int SW = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  localparam int PW = (WRITE_PORTS > 1) ? $clog2(WRITE_PORTS) : 1;

  logic [SOURCES-1:0][ADDRESS_WIDTH-1:0] head_addr;
  logic [SOURCES-1:0][WORD_WIDTH-1:0]    head_data;
  logic [SOURCES-1:0][DW:0]              count;
  logic [SOURCES-1:0] empty, push, grant, drop;
  logic [SW-1:0] rr;

  logic [WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0] nxt_sel;
  logic [WRITE_PORTS-1:0][WORD_WIDTH-1:0]    nxt_data;
  logic [WRITE_PORTS-1:0]                    nxt_en;
  int k, s, last;
  logic hit, zero_head;
  logic [SW-1:0] idx;

  for (genvar g = 0; g < SOURCES; g++) begin : g_src
    assign src_ready_o[g] = !srst_i && (count[g] != (DW+1)'(FIFO_DEPTH));
    assign push[g]        = src_valid_i[g] && src_ready_o[g];
    assign empty[g]       = (count[g] == '0);
    rf_wb_fifo #(.AW(ADDRESS_WIDTH), .WW(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk_i), .srst(srst_i), .push(push[g]), .pop(grant[g] | drop[g]),
      .addr(src_addr_i[g]), .data(src_data_i[g]),
      .head_addr(head_addr[g]), .head_data(head_data[g]), .count(count[g])
    );
  end

  // Round-robin walk from rr; a head is granted only if its address is not already on a port.
  always_comb begin
    grant = '0; drop = '0; nxt_sel = '0; nxt_data = '0; nxt_en = '0;
    k = 0; last = 0; s = 0; hit = 1'b0; zero_head = 1'b0; idx = '0;
    for (int i = 0; i < SOURCES; i++) begin
      s = int'(rr) + i;
      if (s >= SOURCES) s = s - SOURCES;
      idx = SW'(s);
`ifdef RF_WB_ZERO_DROP_EN
      zero_head = (head_addr[idx] == '0);
`else
      zero_head = 1'b0;
`endif
      if (!empty[idx]) begin
        if (zero_head) begin
          drop[idx] = 1'b1;
        end else if (k < WRITE_PORTS) begin
          hit = 1'b0;
          for (int p = 0; p < WRITE_PORTS; p++)
            if (p < k && nxt_sel[p] == head_addr[idx]) hit = 1'b1;
          if (!hit) begin
            grant[idx]         = 1'b1;
            nxt_sel[PW'(k)]  = head_addr[idx];
            nxt_data[PW'(k)] = head_data[idx];
            nxt_en[PW'(k)]   = 1'b1;
            last = s;
            k = k + 1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rr               <= '0;
      select_r_o       <= '0;
      data_o           <= '0;
      enable_writing_o <= '0;
    end else begin
      if (k > 0) rr <= SW'((last + 1) % SOURCES);
      select_r_o       <= nxt_sel;
      data_o           <= nxt_data;
      enable_writing_o <= nxt_en;
    end
  end

  assign busy_o = (|count) | (|enable_writing_o);
endmodule

// File: tb/tb_rf_writeback_scheduler.sv
// Scoreboard bench for rf_writeback_scheduler: expected port writes are queued by the
// stimulus and popped by a monitor whenever any write enable is asserted.
module tb_rf_writeback_scheduler;
  localparam int WW = 32, AW = 5, S = 4, WP = 2, FD = 2;

  logic clk = 1'b0;
  logic srst;
  logic [S-1:0]          src_valid, src_ready;
  logic [S-1:0][AW-1:0]  src_addr;
  logic [S-1:0][WW-1:0]  src_data;
  logic [WP-1:0][AW-1:0] select_r;
  logic [WP-1:0][WW-1:0] data;
  logic [WP-1:0]         enable_writing;
  logic                  busy;

  rf_writeback_scheduler #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .SOURCES(S),
                           .WRITE_PORTS(WP), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .srst_i(srst), .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_addr_i(src_addr), .src_data_i(src_data), .select_r_o(select_r),
    .data_o(data), .enable_writing_o(enable_writing), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WP-1:0]         en;
    logic [WP-1:0][AW-1:0] sel;
    logic [WP-1:0][WW-1:0] data;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int checks = 0, errors = 0;

  function automatic exp_t mk1(logic [AW-1:0] a, logic [WW-1:0] d);
    exp_t e = '0;
    e.en = 2'b01; e.sel[0] = a; e.data[0] = d;
    return e;
  endfunction

  function automatic exp_t mk2(logic [AW-1:0] a0, logic [WW-1:0] d0,
                               logic [AW-1:0] a1, logic [WW-1:0] d1);
    exp_t e = '0;
    e.en = 2'b11; e.sel[0] = a0; e.data[0] = d0; e.sel[1] = a1; e.data[1] = d1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!srst && enable_writing != '0) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got en=%b sel=%h data=%h, required no write",
                 enable_writing, select_r, data);
      end else begin
        mon_e = expq.pop_front();
        if ({enable_writing, select_r, data} !== mon_e) begin
          errors++;
          $display("FAIL port_write: got en=%b sel=%h data=%h, required en=%b sel=%h data=%h",
                   enable_writing, select_r, data, mon_e.en, mon_e.sel, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic cycle(input int n = 1);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic set_src(input int s, input logic [AW-1:0] a, input logic [WW-1:0] d);
    src_valid[s] = 1'b1; src_addr[s] = a; src_data[s] = d;
  endtask

  task automatic do_reset();
    srst = 1'b1; src_valid = '0;
    cycle();
    srst = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach its end within the time bound");
    $fatal(1, "timeout");
  end

  initial begin
    srst = 1'b1; src_valid = '1; src_addr = '0; src_data = '0;
    // reset held two cycles with every source requesting
    cycle(2);
    chk("reset_ready", src_ready, 4'b0000);
    chk("reset_enable", enable_writing, 2'b00);
    srst = 1'b0; src_valid = '0;
    #1;
    chk("ready_after_reset", src_ready, 4'b1111);
    chk("busy_after_reset", busy, 1'b0);

    // single write: enable only at N+1, busy falls at N+2
    set_src(0, 5'd5, 32'hA5);
    expq.push_back(mk1(5'd5, 32'hA5));
    cycle();
    src_valid = '0;
    chk("single_en_N", enable_writing, 2'b00);
    chk("single_busy_N", busy, 1'b1);
    cycle();
    chk("single_en_N1", enable_writing, 2'b01);
    chk("single_busy_N1", busy, 1'b1);
    cycle();
    chk("single_en_N2", enable_writing, 2'b00);
    chk("single_busy_N2", busy, 1'b0);

    // port limit: four sources at once drain two per cycle, rr returns to 0
    do_reset();
    for (int i = 0; i < S; i++) set_src(i, AW'(i + 1), WW'(11 + i));
    expq.push_back(mk2(5'd1, 32'd11, 5'd2, 32'd12));
    expq.push_back(mk2(5'd3, 32'd13, 5'd4, 32'd14));
    cycle();
    src_valid = '0;
    cycle(3);
    set_src(0, 5'd9, 32'h90);
    set_src(3, 5'd8, 32'h80);
    expq.push_back(mk2(5'd9, 32'h90, 5'd8, 32'h80));
    cycle();
    src_valid = '0;
    cycle(2);
    chk("port_limit_idle", busy, 1'b0);

    // address conflict: same register from two sources serialises
    do_reset();
    set_src(0, 5'd7, 32'd1);
    set_src(1, 5'd7, 32'd2);
    expq.push_back(mk1(5'd7, 32'd1));
    expq.push_back(mk1(5'd7, 32'd2));
    cycle();
    src_valid = '0;
    cycle();
    chk("conflict_c1_en", enable_writing, 2'b01);
    cycle();
    chk("conflict_c2_en", enable_writing, 2'b01);
    cycle();
    chk("conflict_idle", busy, 1'b0);

    // backpressure on src2 while its head loses address conflicts
    do_reset();
    set_src(0, 5'd3, 32'h100);
    set_src(1, 5'd3, 32'h101);
    set_src(2, 5'd3, 32'h20);
    expq.push_back(mk1(5'd3, 32'h100));
    expq.push_back(mk1(5'd3, 32'h101));
    expq.push_back(mk1(5'd3, 32'h20));
    expq.push_back(mk1(5'd3, 32'h21));
    expq.push_back(mk1(5'd3, 32'h22));
    cycle();
    src_valid[0] = 1'b0; src_valid[1] = 1'b0;
    src_data[2] = 32'h21;
    cycle();
    chk("bp_full_ready", src_ready[2], 1'b0);
    src_data[2] = 32'h22;
    cycle();
    chk("bp_stall_ready", src_ready[2], 1'b0);
    cycle();
    chk("bp_pop_ready", src_ready[2], 1'b1);
    cycle();
    src_valid = '0;
    cycle(3);
    chk("bp_idle", busy, 1'b0);

    // register 0 handling
    do_reset();
    set_src(1, 5'd0, 32'h30);
    cycle();
    set_src(1, 5'd9, 32'h31);
`ifdef RF_WB_ZERO_DROP_EN
    expq.push_back(mk1(5'd9, 32'h31));
`else
    expq.push_back(mk1(5'd0, 32'h30));
    expq.push_back(mk1(5'd9, 32'h31));
`endif
    cycle();
    src_valid = '0;
`ifdef RF_WB_ZERO_DROP_EN
    chk("zero_first_en", enable_writing, 2'b00);
`else
    chk("zero_first_en", enable_writing, 2'b01);
`endif
    cycle();
    chk("zero_second_en", enable_writing, 2'b01);
    cycle(2);
    chk("zero_idle", busy, 1'b0);

    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
